// File: rtl/atm_account_engine.sv
// Account table (PIN + balance) with lookup/authentication and a three-stage
// request sequencer: accept, check credentials, execute and report.
module atm_account_engine #(
  parameter int          NUM_ACCOUNTS = 10,
  parameter logic [15:0] PIN_BASE     = 16'h1000,
  parameter logic [31:0] INIT_BALANCE = 32'd1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_operation,
  input  logic [3:0]  i_acc_num,
  input  logic [15:0] i_pin,
  input  logic [15:0] i_new_pin,
  input  logic [31:0] i_amount,
  output logic        o_acc_found,
  output logic        o_acc_auth,
  output logic [3:0]  o_acc_index,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_success,
  output logic [31:0] o_balance
);

  // state   | meaning
  // S_IDLE  | waiting for start; request fields latched on acceptance
  // S_CHECK | register found/auth from the latched request
  // S_EXEC  | apply the operation, report success/balance, pulse done
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC} state_t;

  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_WITHDRAW   = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd6;
  localparam logic [3:0] LP_NUM        = 4'(NUM_ACCOUNTS);

  state_t      r_state, w_state_nxt;
  logic        w_accept, w_finish;

  logic [15:0] r_pin_tab [NUM_ACCOUNTS];
  logic [31:0] r_bal_tab [NUM_ACCOUNTS];

  logic [2:0]  r_op;
  logic [3:0]  r_acc;
  logic [15:0] r_pin, r_new_pin;
  logic [31:0] r_amount;
  logic        r_found, r_auth;
  logic [3:0]  r_idx;
  logic        r_done, r_success;
  logic [31:0] r_balance;

  logic        w_lat_found;
  logic [3:0]  w_lat_idx;
  logic [31:0] w_cur_bal;
  logic [32:0] w_sum;
  logic        w_ok, w_wr_bal, w_wr_pin;
  logic [31:0] w_new_bal, w_bal_out;

  // Live lookup against the current table, independent of the sequencer
  assign o_acc_found = (i_acc_num < LP_NUM);
  assign o_acc_index = o_acc_found ? i_acc_num : 4'd0;
  assign o_acc_auth  = o_acc_found && (i_pin == r_pin_tab[o_acc_index]);

  assign o_done    = r_done;
  assign o_success = r_success;
  assign o_balance = r_balance;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        o_busy      = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        o_busy      = 1'b1;
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op      <= 3'd0;
      r_acc     <= 4'd0;
      r_pin     <= 16'd0;
      r_new_pin <= 16'd0;
      r_amount  <= 32'd0;
    end else if (w_accept) begin
      r_op      <= i_operation;
      r_acc     <= i_acc_num;
      r_pin     <= i_pin;
      r_new_pin <= i_new_pin;
      r_amount  <= i_amount;
    end
  end

  assign w_lat_found = (r_acc < LP_NUM);
  assign w_lat_idx   = w_lat_found ? r_acc : 4'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_found <= 1'b0;
      r_auth  <= 1'b0;
      r_idx   <= 4'd0;
    end else if (r_state == S_CHECK) begin
      r_found <= w_lat_found;
      r_auth  <= w_lat_found && (r_pin == r_pin_tab[w_lat_idx]);
      r_idx   <= w_lat_idx;
    end
  end

  assign w_cur_bal = r_bal_tab[r_idx];
  assign w_sum     = {1'b0, w_cur_bal} + {1'b0, r_amount};

  // A failed authentication leaves the reported balance untouched
  always_comb begin
    w_ok      = 1'b0;
    w_wr_bal  = 1'b0;
    w_wr_pin  = 1'b0;
    w_new_bal = w_cur_bal;
    w_bal_out = r_balance;
    if (r_found && r_auth) begin
      w_bal_out = w_cur_bal;
      case (r_op)
        OP_BALANCE: w_ok = 1'b1;
        OP_WITHDRAW: begin
          if (r_amount <= w_cur_bal) begin
            w_ok      = 1'b1;
            w_wr_bal  = 1'b1;
            w_new_bal = w_cur_bal - r_amount;
            w_bal_out = w_new_bal;
          end
        end
        OP_DEPOSIT: begin
          if (!w_sum[32]) begin
            w_ok      = 1'b1;
            w_wr_bal  = 1'b1;
            w_new_bal = w_sum[31:0];
            w_bal_out = w_new_bal;
          end
        end
        OP_CHANGE_PIN: begin
          if (r_new_pin != r_pin_tab[r_idx]) begin
            w_ok     = 1'b1;
            w_wr_pin = 1'b1;
          end
        end
        default: w_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_pin_tab[i] <= PIN_BASE + 16'(i);
        r_bal_tab[i] <= INIT_BALANCE;
      end
    end else if (w_finish) begin
      if (w_wr_bal) r_bal_tab[r_idx] <= w_new_bal;
      if (w_wr_pin) r_pin_tab[r_idx] <= r_new_pin;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done    <= 1'b0;
      r_success <= 1'b0;
      r_balance <= 32'd0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_success <= w_ok;
        r_balance <= w_bal_out;
      end
    end
  end

endmodule

// File: tb/tb_atm_account_engine.sv
// Self-checking bench: directed scenarios followed by random requests, all
// checked against an account-table model kept in plain arithmetic.
module tb_atm_account_engine;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_operation = 3'd0;
  logic [3:0]  i_acc_num = 4'd0;
  logic [15:0] i_pin = 16'd0;
  logic [15:0] i_new_pin = 16'd0;
  logic [31:0] i_amount = 32'd0;
  logic        o_acc_found, o_acc_auth, o_busy, o_done, o_success;
  logic [3:0]  o_acc_index;
  logic [31:0] o_balance;

  atm_account_engine dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_operation(i_operation),
    .i_acc_num(i_acc_num), .i_pin(i_pin), .i_new_pin(i_new_pin), .i_amount(i_amount),
    .o_acc_found(o_acc_found), .o_acc_auth(o_acc_auth), .o_acc_index(o_acc_index),
    .o_busy(o_busy), .o_done(o_done), .o_success(o_success), .o_balance(o_balance)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_pin [10];
  longint      m_bal [10];
  longint      m_balance;
  bit          m_success;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_pin[i] = 16'h1000 + 16'(i);
      m_bal[i] = 1000;
    end
    m_balance = 0;
    m_success = 0;
  endtask

  task automatic model_apply(input int op, input int acc, input logic [15:0] p,
                             input logic [15:0] np, input longint amt);
    m_success = 0;
    if (acc < 10 && p == m_pin[acc]) begin
      case (op)
        3: m_success = 1;
        4: if (amt <= m_bal[acc]) begin m_bal[acc] -= amt; m_success = 1; end
        5: if (m_bal[acc] + amt <= 64'hFFFF_FFFF) begin m_bal[acc] += amt; m_success = 1; end
        6: if (np != m_pin[acc]) begin m_pin[acc] = np; m_success = 1; end
        default: m_success = 0;
      endcase
      m_balance = m_bal[acc];
    end
  endtask

  // Issue one request; optionally re-strobe start with junk inputs while busy.
  task automatic run_req(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                         input logic [15:0] np, input logic [31:0] amt, input bit scramble);
    int  cycles;
    bit  exp_found, exp_auth;
    @(posedge i_clk); #1;
    i_operation = op; i_acc_num = acc; i_pin = p; i_new_pin = np; i_amount = amt;
    i_start = 1'b1;
    #1;
    exp_found = (int'(acc) < 10);
    exp_auth  = exp_found && (p == m_pin[exp_found ? int'(acc) : 0]);
    chk("acc_found", o_acc_found, exp_found);
    chk("acc_auth", o_acc_auth, exp_auth);
    chk("acc_index", o_acc_index, exp_found ? acc : 4'd0);
    @(posedge i_clk); #1;
    chk("busy_after_accept", o_busy, 1'b1);
    i_start = scramble;
    if (scramble) begin
      i_operation = 3'($urandom_range(3, 6)); i_acc_num = 4'($urandom_range(0, 9));
      i_pin = 16'($urandom); i_new_pin = 16'($urandom); i_amount = $urandom;
    end
    cycles = 1;
    while (!o_done && cycles < 10) begin
      @(posedge i_clk); #1;
      cycles++;
      i_start = 1'b0;
    end
    chk("done_latency", cycles, 3);
    chk("busy_at_done", o_busy, 1'b0);
    model_apply(int'(op), int'(acc), p, np, longint'(amt));
    chk("success", o_success, m_success);
    chk("balance", o_balance, m_balance);
    @(posedge i_clk); #1;
    chk("done_single", o_done, 1'b0);
    chk("idle_after_done", o_busy, 1'b0);
  endtask

  initial begin
    int acc, op;
    logic [15:0] p, np;
    logic [31:0] amt;

    model_reset();
    i_rst = 1'b1;
    #12;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_success", o_success, 1'b0);
    chk("rst_balance", o_balance, 32'd0);
    @(negedge i_clk); i_rst = 1'b0;

    run_req(3'd3, 4'd2, 16'h1002, 16'h0, 32'd0, 0);
    chk("plan_bal2", o_balance, 32'd1000);
    run_req(3'd4, 4'd2, 16'h1002, 16'h0, 32'd300, 0);
    chk("plan_wd300", o_balance, 32'd700);
    run_req(3'd4, 4'd2, 16'h1002, 16'h0, 32'd701, 0);
    chk("plan_wd701_succ", o_success, 1'b0);
    chk("plan_wd701_bal", o_balance, 32'd700);
    run_req(3'd4, 4'd2, 16'h1002, 16'h0, 32'd700, 0);
    chk("plan_wd_exact", o_balance, 32'd0);
    run_req(3'd5, 4'd5, 16'h1005, 16'h0, 32'd250, 0);
    chk("plan_dep250", o_balance, 32'd1250);
    run_req(3'd5, 4'd5, 16'h1005, 16'h0, 32'hFFFF_FFFF, 0);
    chk("plan_dep_ovf_succ", o_success, 1'b0);
    chk("plan_dep_ovf_bal", o_balance, 32'd1250);
    run_req(3'd4, 4'd5, 16'h1005, 16'h0, 32'd0, 0);
    run_req(3'd5, 4'd5, 16'h1005, 16'h0, 32'd0, 0);
    run_req(3'd6, 4'd7, 16'h1007, 16'hBEEF, 32'd0, 0);
    chk("plan_chpin", o_success, 1'b1);
    run_req(3'd3, 4'd7, 16'h1007, 16'h0, 32'd0, 0);
    chk("plan_oldpin", o_success, 1'b0);
    run_req(3'd3, 4'd7, 16'hBEEF, 16'h0, 32'd0, 0);
    chk("plan_newpin_bal", o_balance, 32'd1000);
    run_req(3'd6, 4'd7, 16'hBEEF, 16'hBEEF, 32'd0, 0);
    run_req(3'd4, 4'd12, 16'h1000, 16'h0, 32'd10, 0);
    run_req(3'd4, 4'd0, 16'h1234, 16'h0, 32'd10, 0);
    run_req(3'd7, 4'd0, 16'h1000, 16'h0, 32'd10, 0);
    run_req(3'd3, 4'd0, 16'h1000, 16'h0, 32'd0, 0);
    chk("plan_acc0_intact", o_balance, 32'd1000);
    run_req(3'd4, 4'd1, 16'h1001, 16'h0, 32'd5, 1);

    // Reset while in CHECK: request aborted, tables restored
    @(posedge i_clk); #1;
    i_operation = 3'd4; i_acc_num = 4'd3; i_pin = 16'h1003; i_amount = 32'd100;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_done", o_done, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_rst = 1'b0;
    model_reset();
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge i_clk); #1;
        if (o_done) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    run_req(3'd3, 4'd2, 16'h1002, 16'h0, 32'd0, 0);
    chk("post_rst_bal2", o_balance, 32'd1000);
    run_req(3'd3, 4'd3, 16'h1003, 16'h0, 32'd0, 0);

    for (int n = 0; n < 250; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(3, 6));
      acc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      p   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : m_pin[acc < 10 ? acc : 0];
      np  = ($urandom_range(0, 3) == 0) ? m_pin[acc < 10 ? acc : 0] : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       amt = $urandom_range(0, 50);
        1:       amt = $urandom_range(0, 2000);
        2:       amt = $urandom;
        default: amt = (acc < 10) ? 32'(m_bal[acc]) : 32'd0;
      endcase
      run_req(3'(op), 4'(acc), p, np, amt, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
